ag32gbd_capture_seq: RTL

- Capture sequencer downstream of the cart-bus register block.
- Consumes the capture trigger (A000 bit 0) and the exposure registers A002/A003.
- Times the exposure, then hands off to the frame readout/BRAM writer via a start/done handshake.
- Returns the Sig_CamCaptureFinish level that the register block edge-detects to clear A000.

---
 rtl/ag32gbd_capture_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ag32gbd_capture_seq.sv
// Capture sequencer: times the camera exposure from A002/A003, requests a frame
// readout, then holds Sig_CamCaptureFinish so the register block can clear A000.
module ag32gbd_capture_seq #(
   parameter int unsigned TICK_DIV        = 16,
   parameter int unsigned FINISH_HOLD     = 4,
   parameter int unsigned READOUT_TIMEOUT = 1048576
) (
   input  logic       sys_clock,
   input  logic       sys_reset,
   input  logic       Cam_Capture,
   input  logic [7:0] Reg_A002,
   input  logic [7:0] Reg_A003,
   output logic       Frame_Start,
   input  logic       Frame_Done,
   output logic       Sig_CamCaptureFinish,
   output logic       Exposure_Active,
   output logic       Busy,
   output logic       Timeout_Flag
);

   localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CntMax = (READOUT_TIMEOUT > FINISH_HOLD) ? READOUT_TIMEOUT
                                                                     : FINISH_HOLD;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   localparam logic [PreW-1:0] PreLoad = PreW'(TICK_DIV - 1);
   localparam logic [CntW-1:0] RoLast  = CntW'(READOUT_TIMEOUT - 1);
   localparam logic [CntW-1:0] FinLast = CntW'(FINISH_HOLD - 1);

   typedef enum logic [2:0] {StIdle, StExpose, StReadout, StFinish, StWaitClr} state_e;

   state_e            r_state;
   state_e            w_state_next;
   logic              r_cap_d;
   logic              r_armed;    // a low Cam_Capture has been seen since reset
   logic [PreW-1:0]   r_presc;
   logic [15:0]       r_units;
   logic [CntW-1:0]   r_cnt;      // readout elapsed cycles, then finish hold cycles
   logic              r_timeout;

   logic              w_start;
   logic [15:0]       w_exposure;
   logic [15:0]       w_units_init;
   logic              w_expose_end;
   logic              w_done_ok;
   logic              w_ro_expired;

   // A level held through reset release must not look like a fresh request.
   assign w_start      = Cam_Capture & ~r_cap_d & r_armed;
   assign w_exposure   = {Reg_A002, Reg_A003};
   assign w_units_init = (w_exposure == 16'd0) ? 16'd0 : w_exposure - 16'd1;
   assign w_expose_end = (r_presc == '0) && (r_units == 16'd0);
   // Frame_Done coincident with Frame_Start (elapsed count 0) is ignored.
   assign w_done_ok    = Frame_Done && (r_cnt != '0);
   assign w_ro_expired = (r_cnt == RoLast);

   // State register.
   always_ff @(posedge sys_clock or posedge sys_reset) begin
      if (sys_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode; abort beats expiry, Frame_Done beats timeout.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:    if (w_start) w_state_next = StExpose;
         StExpose: begin
            if (!Cam_Capture)      w_state_next = StIdle;
            else if (w_expose_end) w_state_next = StReadout;
         end
         StReadout: if (w_done_ok || w_ro_expired) w_state_next = StFinish;
         StFinish:  if (r_cnt == FinLast) w_state_next = StWaitClr;
         StWaitClr: if (!Cam_Capture) w_state_next = StIdle;
         default:   w_state_next = StIdle;
      endcase
   end

   // Exposure counters, readout/finish counter, edge history and timeout flag.
   always_ff @(posedge sys_clock or posedge sys_reset) begin
      if (sys_reset) begin
         r_cap_d   <= 1'b0;
         r_armed   <= 1'b0;
         r_presc   <= '0;
         r_units   <= 16'd0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cap_d <= Cam_Capture;
         if (!Cam_Capture) r_armed <= 1'b1;
         unique case (r_state)
            StIdle: begin
               r_cnt <= '0;
               if (w_start) begin
                  r_presc   <= PreLoad;
                  r_units   <= w_units_init;
                  r_timeout <= 1'b0;
               end
            end
            StExpose: begin
               r_cnt <= '0;
               if (r_presc != '0) begin
                  r_presc <= r_presc - PreW'(1);
               end else if (r_units != 16'd0) begin
                  r_presc <= PreLoad;
                  r_units <= r_units - 16'd1;
               end
            end
            StReadout: begin
               if (w_state_next == StFinish) r_cnt <= '0;
               else                          r_cnt <= r_cnt + CntW'(1);
               if (w_ro_expired && !w_done_ok) r_timeout <= 1'b1;
            end
            StFinish: r_cnt <= r_cnt + CntW'(1);
            default:  r_cnt <= '0;
         endcase
      end
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      Frame_Start          = (r_state == StReadout) && (r_cnt == '0);
      Sig_CamCaptureFinish = (r_state == StFinish);
      Exposure_Active      = (r_state == StExpose);
      Busy                 = (r_state != StIdle);
      Timeout_Flag         = r_timeout;
   end

endmodule
